// File: rtl/st7789_pkg.sv
// Shared types and constants for the ST7789 window scheduler.
package st7789_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int RECT_W  = 32;
    localparam int COLOR_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CA_CMD,
        ST_CA_ARG,
        ST_RA_CMD,
        ST_RA_ARG,
        ST_WR_CMD,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_FIN
    } state_t;

    // Field order matches the packed request word {x0, y0, x1, y1}.
    typedef struct packed {
        logic [7:0] x0;
        logic [7:0] y0;
        logic [7:0] x1;
        logic [7:0] y1;
    } rect_t;

    function automatic logic [7:0] arg_byte(input logic [15:0] a_start,
                                            input logic [15:0] a_end,
                                            input logic [1:0]  idx);
        case (idx)
            2'd0:    return a_start[15:8];
            2'd1:    return a_start[7:0];
            2'd2:    return a_end[15:8];
            default: return a_end[7:0];
        endcase
    endfunction

endpackage

// File: rtl/st7789_rr_arbiter.sv
// Two-way round-robin arbiter; the last-winner pointer moves only when upd is pulsed.
module st7789_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       any,
    output logic       win_idx
);

    logic last_q, last_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (upd) last_d = upd_idx;
    end

    always_comb begin
        any     = |req;
        win_idx = 1'b0;
        if (req == 2'b11) win_idx = ~last_q;
        else if (req[1])  win_idx = 1'b1;
    end

endmodule

// File: rtl/st7789_window_scheduler.sv
// Arbitrates two rectangle requesters and emits CASET/RASET/RAMWR plus pixel bytes to the SPI shifter.
//   state     | meaning
//   IDLE      | wait for a request, latch rect and owner
//   CA_CMD    | offer 0x2A
//   CA_ARG    | offer 4 column address bytes
//   RA_CMD    | offer 0x2B
//   RA_ARG    | offer 4 row address bytes
//   WR_CMD    | offer 0x2C
//   PIX_HI    | offer colour high byte
//   PIX_LO    | offer colour low byte, advance px/py on accept
//   FIN       | done (and err) pulse, pointer update, release grant
module st7789_window_scheduler
    import st7789_pkg::*;
#(
    parameter int C_x_size   = 128,
    parameter int C_y_size   = 160,
    parameter int C_x_offset = 0,
    parameter int C_y_offset = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [63:0] req_rect,
    input  logic [31:0] req_color,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        err,
    output logic [7:0]  px,
    output logic [7:0]  py,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    input  logic        byte_ready
);

    localparam logic [15:0] X_SIZE = 16'(C_x_size);
    localparam logic [15:0] Y_SIZE = 16'(C_y_size);
    localparam logic [15:0] X_OFF  = 16'(C_x_offset);
    localparam logic [15:0] Y_OFF  = 16'(C_y_offset);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [1:0]  grant_q, grant_d;
    logic        err_q, err_d;
    rect_t       rect_q, rect_d;
    logic [1:0]  arg_q, arg_d;
    logic [14:0] cnt_q, cnt_d;
    logic [7:0]  px_q, px_d, py_q, py_d;
    logic [15:0] color_q, color_d;
    logic        hold_q, hold_d;

    logic        arb_any, arb_win, arb_upd;
    rect_t       sel_rect;
    logic        rect_ok;
    logic [8:0]  rect_w, rect_h;
    logic [14:0] npix;
    logic [15:0] live_color;
    logic [15:0] col_start, col_end, row_start, row_end;
    logic        accept;

    assign arb_upd = (state_q == ST_FIN);

    st7789_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .upd     (arb_upd),
        .upd_idx (owner_q),
        .any     (arb_any),
        .win_idx (arb_win)
    );

    assign accept     = byte_valid & byte_ready;
    assign sel_rect   = arb_win ? rect_t'(req_rect[2*RECT_W-1:RECT_W]) : rect_t'(req_rect[RECT_W-1:0]);
    assign live_color = owner_q ? req_color[2*COLOR_W-1:COLOR_W] : req_color[COLOR_W-1:0];
    assign rect_ok    = (sel_rect.x0 <= sel_rect.x1) && ({8'h00, sel_rect.x1} < X_SIZE) &&
                        (sel_rect.y0 <= sel_rect.y1) && ({8'h00, sel_rect.y1} < Y_SIZE);
    assign rect_w     = {1'b0, sel_rect.x1} - {1'b0, sel_rect.x0} + 9'd1;
    assign rect_h     = {1'b0, sel_rect.y1} - {1'b0, sel_rect.y0} + 9'd1;
    assign npix       = 15'(rect_w) * 15'(rect_h);
    assign col_start  = {8'h00, rect_q.x0} + X_OFF;
    assign col_end    = {8'h00, rect_q.x1} + X_OFF;
    assign row_start  = {8'h00, rect_q.y0} + Y_OFF;
    assign row_end    = {8'h00, rect_q.y1} + Y_OFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_any) state_d = rect_ok ? ST_CA_CMD : ST_FIN;
            ST_CA_CMD: if (accept) state_d = ST_CA_ARG;
            ST_CA_ARG: if (accept && arg_q == 2'd3) state_d = ST_RA_CMD;
            ST_RA_CMD: if (accept) state_d = ST_RA_ARG;
            ST_RA_ARG: if (accept && arg_q == 2'd3) state_d = ST_WR_CMD;
            ST_WR_CMD: if (accept) state_d = ST_PIX_HI;
            ST_PIX_HI: if (accept) state_d = ST_PIX_LO;
            ST_PIX_LO: if (accept) state_d = (cnt_q == 15'd0) ? ST_FIN : ST_PIX_HI;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_dc    = 1'b0;
        done       = 2'b00;
        err        = 1'b0;
        case (state_q)
            ST_CA_CMD: begin byte_valid = 1'b1; byte_data = CMD_CASET; end
            ST_CA_ARG: begin byte_valid = 1'b1; byte_dc = 1'b1; byte_data = arg_byte(col_start, col_end, arg_q); end
            ST_RA_CMD: begin byte_valid = 1'b1; byte_data = CMD_RASET; end
            ST_RA_ARG: begin byte_valid = 1'b1; byte_dc = 1'b1; byte_data = arg_byte(row_start, row_end, arg_q); end
            ST_WR_CMD: begin byte_valid = 1'b1; byte_data = CMD_RAMWR; end
            // First PIX_HI cycle passes the live colour; a stall falls back to the sampled copy.
            ST_PIX_HI: begin byte_valid = 1'b1; byte_dc = 1'b1; byte_data = hold_q ? color_q[15:8] : live_color[15:8]; end
            ST_PIX_LO: begin byte_valid = 1'b1; byte_dc = 1'b1; byte_data = color_q[7:0]; end
            ST_FIN:    begin done = grant_q; err = err_q; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            grant_q <= 2'b00;
            err_q   <= 1'b0;
            rect_q  <= '0;
            arg_q   <= 2'd0;
            cnt_q   <= 15'd0;
            px_q    <= 8'h00;
            py_q    <= 8'h00;
            color_q <= 16'h0000;
            hold_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            rect_q  <= rect_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            px_q    <= px_d;
            py_q    <= py_d;
            color_q <= color_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        grant_d = grant_q;
        err_d   = err_q;
        rect_d  = rect_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        px_d    = px_q;
        py_d    = py_q;
        color_d = color_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    owner_d = arb_win;
                    grant_d = arb_win ? 2'b10 : 2'b01;
                    err_d   = ~rect_ok;
                    rect_d  = sel_rect;
                    px_d    = sel_rect.x0;
                    py_d    = sel_rect.y0;
                    cnt_d   = npix - 15'd1;
                end
            end
            ST_CA_CMD, ST_RA_CMD: arg_d = 2'd0;
            ST_CA_ARG, ST_RA_ARG: if (accept) arg_d = arg_q + 2'd1;
            ST_PIX_HI: begin
                if (!hold_q) color_d = live_color;
                hold_d = ~accept;
            end
            ST_PIX_LO: begin
                if (accept && cnt_q != 15'd0) begin
                    cnt_d = cnt_q - 15'd1;
                    if (px_q == rect_q.x1) begin
                        px_d = rect_q.x0;
                        py_d = py_q + 8'd1;
                    end else begin
                        px_d = px_q + 8'd1;
                    end
                end
            end
            ST_FIN: begin
                grant_d = 2'b00;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign grant = grant_q;
    assign px    = px_q;
    assign py    = py_q;

endmodule

// File: doc/st7789_window_scheduler.md
# st7789_window_scheduler

Two-requester scheduler for the ST7789 SPI panel. It arbitrates rectangular update requests round-robin and emits the command/argument byte sequence CASET, RASET, RAMWR. It then streams the granted requester's 16-bit pixels, high byte first, into the downstream byte-serial SPI shifter. It sits between pixel producers (e.g. sprite/text engines) and the display transmit core; panel init is complete before any request is raised.

## Interface
Parameters:
- C_x_size, 128, panel width in pixels
- C_y_size, 160, panel height in pixels
- C_x_offset, 0, added to column addresses (16-bit arithmetic)
- C_y_offset, 0, added to row addresses (16-bit arithmetic)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- req  in  2  request per requester; held high until its done pulse
- req_rect  in  64  requester i at [32i+31:32i] = {x0,y0,x1,y1}, 8 bits each, inclusive
- req_color  in  32  requester i pixel at [16i+15:16i], RGB565
- grant  out  2  one-hot owner of current transfer; 0 when idle
- done  out  2  one-cycle pulse to owner after last byte accepted
- err  out  1  one-cycle pulse with done when the rectangle was rejected
- px, py  out  8 each  coordinate of the pixel the owner must present next
- byte_valid  out  1  byte offered to shifter
- byte_data  out  8  byte value
- byte_dc  out  1  0 = command, 1 = data
- byte_ready  in  1  shifter accepts when valid && ready

## Operation
- States: IDLE, CA_CMD, CA_ARG(4), RA_CMD, RA_ARG(4), WR_CMD, PIX_HI, PIX_LO, FIN.
- IDLE: if any req, select via round-robin. The last-winner pointer resets to 1, so requester 0 wins the first tie. Latch rect; set grant.
- Validation at grant: x0<=x1<C_x_size and y0<=y1<C_y_size.
  - On failure go to FIN with err=1; no bytes emitted.
- Byte sequence:
  - 0x2A (dc=0), then x0+off hi, lo, x1+off hi, lo (dc=1).
  - 0x2B, then y0/y1 likewise.
  - 0x2C (dc=0).
  - Per pixel: color[15:8], color[7:0] (dc=1).
- Pixel order: x fastest, x0..x1 then y+1; px/py start at x0/y0.
- Pixel count = (x1-x0+1)*(y1-y0+1), 15-bit counter (max 20480).
- req_color[owner] is sampled on entry to PIX_HI. px/py advance on the edge the PIX_LO byte is accepted, so the owner gets at least one cycle of registered latency.
- FIN: done[owner] for one cycle, grant to 0, pointer updated. Return to IDLE; at least one idle cycle before the next grant.
- A req deasserted mid-transfer is ignored; the transfer completes. Rect/color changes after grant affect only color.

## Timing
- Reset values: grant=0, done=0, err=0, byte_valid=0, byte_data=0, byte_dc=0, px=0, py=0, state IDLE, pointer=1.
- Grant is registered one cycle after req is seen in IDLE. byte_valid rises the same cycle as grant, carrying 0x2A.
- byte_data/byte_dc stay stable while byte_valid && !byte_ready. With ready held high, one byte per cycle.
- Minimum request latency is 1 + 11 command/argument cycles + 2N pixel cycles + 1 FIN cycle.
- Reset asserted mid-transfer: all outputs return to reset values immediately. The shifter is reset from the same source.
- Simultaneous req=2'b11 in IDLE: grant goes to the requester not granted last.

## Structure
- Package st7789_pkg: command constants (CASET 0x2A, RASET 0x2B, RAMWR 0x2C), state enum, rect field offsets.
- Sub-module st7789_rr_arbiter: 2-way round-robin with a pointer update input pulsed in FIN.

## Test plan
- req=01, rect {0,0,1,0}, ready=1 -> bytes 2A 00 00 00 01 2B 00 00 00 00 2C, then 4 pixel bytes; done=01; dc=0 only on the three commands.
- req=11 twice in sequence -> grants 01 then 10, then 01 if both are still requesting.
- C_x_offset=52, rect x0=0,x1=127 -> CASET args 00 34 00 B3.
- Rect {5,0,4,0} or x1=128 -> err and done pulse together, no byte_valid.
- Random byte_ready stalls over rect {0,0,2,1} -> byte stream identical to the no-stall run; px/py sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1).
- Reset in the middle of PIX_LO -> next cycle all outputs 0; a new req restarts from 0x2A.
